// File: rtl/if_id_pkg.sv
// IF/ID stage shared definitions: instruction field
// positions and the decoded-field bundle.
package if_id_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 28;
  localparam int COND_HI  = 27;
  localparam int COND_LO  = 26;
  localparam int F_HI     = 25;
  localparam int F_LO     = 24;
  localparam int RG_HI    = 23;
  localparam int RG_LO    = 20;
  localparam int RP_HI    = 19;
  localparam int RP_LO    = 16;
  localparam int RS_HI    = 15;
  localparam int RS_LO    = 12;
  localparam int INM_HI   = 15;
  localparam int INM_LO   = 0;
  localparam int LABEL_HI = 23;
  localparam int LABEL_LO = 0;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [1:0]  cond;
    logic [1:0]  f;
    logic [3:0]  rg;
    logic [3:0]  rp;
    logic [3:0]  rs;
    logic [15:0] inm;
    logic [23:0] label;
  } if_id_fields_t;

endpackage

// File: rtl/if_id_field_decode.sv
// Combinational instruction field slicer, shared by
// the IF/ID stage and later decode stages.
module if_id_field_decode
  import if_id_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output if_id_fields_t      o_fields
);

  always_comb begin
    o_fields        = '0;
    o_fields.opcode = i_instr[OPC_HI:OPC_LO];
    o_fields.cond   = i_instr[COND_HI:COND_LO];
    o_fields.f      = i_instr[F_HI:F_LO];
    o_fields.rg     = i_instr[RG_HI:RG_LO];
    o_fields.rp     = i_instr[RP_HI:RP_LO];
    o_fields.rs     = i_instr[RS_HI:RS_LO];
    o_fields.inm    = i_instr[INM_HI:INM_LO];
    o_fields.label  = i_instr[LABEL_HI:LABEL_LO];
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID handshake stage: main register plus one skid
// entry, flush-to-bubble, field decode, stall counter.
module if_id_stage
  import if_id_pkg::*;
#(
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc4,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc4,
  output logic [3:0]         opcode,
  output logic [1:0]         cond,
  output logic [1:0]         f,
  output logic [3:0]         rg,
  output logic [3:0]         rp,
  output logic [3:0]         rs,
  output logic [15:0]        inm,
  output logic [23:0]        label,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic               r_main_valid;
  logic [INSTR_W-1:0] r_main_instr;
  logic [PC_W-1:0]    r_main_pc4;
  logic               r_skid_valid;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [PC_W-1:0]    r_skid_pc4;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic          w_acc;
  logic          w_dlv;
  logic          w_stall;
  if_id_fields_t w_fields;

  // in_ready depends only on a flop, never on out_ready
  assign in_ready  = !r_skid_valid;
  assign out_valid = r_main_valid;
  assign out_instr = r_main_instr;
  assign out_pc4   = r_main_pc4;
  assign stall_cnt = r_stall_cnt;

  assign w_acc   = in_valid && in_ready;
  assign w_dlv   = r_main_valid && out_ready;
  assign w_stall = r_main_valid && !out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_instr <= NOP_INSTR;
      r_main_pc4   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc4   <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_main_instr <= NOP_INSTR;
      r_main_pc4   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc4   <= '0;
    end else if (!r_main_valid || w_dlv) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_instr <= r_skid_instr;
        r_main_pc4   <= r_skid_pc4;
        r_skid_valid <= 1'b0;
        r_skid_instr <= NOP_INSTR;
        r_skid_pc4   <= '0;
      end else if (w_acc) begin
        r_main_valid <= 1'b1;
        r_main_instr <= in_instr;
        r_main_pc4   <= in_pc4;
      end else begin
        r_main_valid <= 1'b0;
        r_main_instr <= NOP_INSTR;
        r_main_pc4   <= '0;
      end
    end else if (w_acc) begin
      r_skid_valid <= 1'b1;
      r_skid_instr <= in_instr;
      r_skid_pc4   <= in_pc4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  if_id_field_decode u_dec (
    .i_instr  (r_main_instr),
    .o_fields (w_fields)
  );

  assign opcode = w_fields.opcode;
  assign cond   = w_fields.cond;
  assign f      = w_fields.f;
  assign rg     = w_fields.rg;
  assign rp     = w_fields.rp;
  assign rs     = w_fields.rs;
  assign inm    = w_fields.inm;
  assign label  = w_fields.label;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: occupancy model with
// expected/observed delivery queues and a stall-count model.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc4;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
  logic [3:0]  opcode;
  logic [1:0]  cond;
  logic [1:0]  f;
  logic [3:0]  rg;
  logic [3:0]  rp;
  logic [3:0]  rs;
  logic [15:0] inm;
  logic [23:0] label;
  logic [3:0]  stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_out_q[$];
  logic [63:0] got_q[$];
  logic [3:0]  m_stall;

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  if_id_stage #(
    .PC_W      (32),
    .NOP_INSTR (32'h0000_0000),
    .CNT_W     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc4    (in_pc4),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc4   (out_pc4),
    .opcode    (opcode),
    .cond      (cond),
    .f         (f),
    .rg        (rg),
    .rp        (rp),
    .rs        (rs),
    .inm       (inm),
    .label     (label),
    .stall_cnt (stall_cnt)
  );

  // One clock: update the model at negedge, then advance to edge+1
  task automatic tick();
    bit mv, mr, macc, mdlv;
    @(negedge clk);
    mv   = exp_q.size() != 0;
    mr   = exp_q.size() < 2;
    macc = in_valid && mr;
    mdlv = mv && out_ready;
    if (mv && !out_ready && m_stall != 4'hF) m_stall++;
    if (mdlv) exp_out_q.push_back(exp_q.pop_front());
    if (out_valid && out_ready) got_q.push_back({out_instr, out_pc4});
    if (flush) exp_q.delete();
    else if (macc) exp_q.push_back({in_instr, in_pc4});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = 32'h0;
    in_pc4 = 32'h0;
    flush = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_out_q.delete();
    got_q.delete();
    m_stall = 4'h0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 4'h0)
      $display("FAIL reset_init: valid=%b ready=%b stall=%0d want 0 1 0",
               out_valid, in_ready, stall_cnt);
    else n_pass++;
    in_valid = 1'b1;
    in_instr = 32'hA000_0001;
    in_pc4 = 32'h10;
    tick();
    in_instr = 32'hB000_0002;
    in_pc4 = 32'h14;
    tick();
    tick();
    n_total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL reset_full: ready=%b valid=%b want 0 1", in_ready, out_valid);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || opcode !== 4'h0 ||
        stall_cnt !== 4'h0 || out_instr !== 32'h0)
      $display("FAIL reset_async: valid=%b ready=%b opc=%h stall=%0d instr=%h want 0 1 0 0 0",
               out_valid, in_ready, opcode, stall_cnt, out_instr);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_decode();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h0001_7000;
    in_pc4 = 32'd4;
    tick();
    n_total++;
    if (out_valid !== 1'b1 || opcode !== 4'h0 || rg !== 4'h0 || rp !== 4'h1 ||
        rs !== 4'h7 || inm !== 16'h7000 || out_pc4 !== 32'd4)
      $display("FAIL decode_a: v=%b opc=%h rg=%h rp=%h rs=%h inm=%h pc4=%0d want 1 0 0 1 7 7000 4",
               out_valid, opcode, rg, rp, rs, inm, out_pc4);
    else n_pass++;
    in_instr = 32'h1175_B000;
    in_pc4 = 32'd8;
    tick();
    n_total++;
    if (opcode !== 4'h1 || cond !== 2'd0 || f !== 2'd1 || rg !== 4'h7 ||
        rp !== 4'h5 || rs !== 4'hB || label !== 24'h75B000)
      $display("FAIL decode_b: opc=%h cond=%0d f=%0d rg=%h rp=%h rs=%h label=%h want 1 0 1 7 5 b 75b000",
               opcode, cond, f, rg, rp, rs, label);
    else n_pass++;
    in_instr = 32'h9E7F_1234;
    in_pc4 = 32'd12;
    tick();
    n_total++;
    if (opcode !== 4'h9 || cond !== 2'd3 || f !== 2'd2 || rg !== 4'h7 ||
        rp !== 4'hF || rs !== 4'h1 || inm !== 16'h1234 || label !== 24'h7F1234)
      $display("FAIL decode_ext: opc=%h cond=%0d f=%0d rg=%h rp=%h rs=%h inm=%h label=%h want 9 3 2 7 f 1 1234 7f1234",
               opcode, cond, f, rg, rp, rs, inm, label);
    else n_pass++;
    in_valid = 1'b0;
    tick();
    n_total++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || opcode !== 4'h0 || out_pc4 !== 32'h0)
      $display("FAIL decode_bubble: v=%b instr=%h pc4=%0d want 0 0 0",
               out_valid, out_instr, out_pc4);
    else n_pass++;
    n_total++;
    if (got_q.size() !== 3 || exp_out_q.size() !== 3)
      $display("FAIL decode_count: got=%0d want 3 (model %0d)", got_q.size(), exp_out_q.size());
    else n_pass++;
    while (got_q.size() != 0 && exp_out_q.size() != 0) begin
      logic [63:0] g, e;
      g = got_q.pop_front();
      e = exp_out_q.pop_front();
      n_total++;
      if (g !== e) $display("FAIL decode_order: got %h want %h", g, e);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int guard;
    do_reset();
    in_valid = 1'b1;
    in_instr = 32'h2000_0004;
    in_pc4 = 32'd4;
    tick();
    in_instr = 32'h3000_0008;
    in_pc4 = 32'd8;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL bp_ready1: got %b want 1", in_ready);
    else n_pass++;
    tick();
    n_total++;
    if (in_ready !== 1'b0 || stall_cnt !== m_stall)
      $display("FAIL bp_ready0: ready=%b stall=%0d want 0 %0d", in_ready, stall_cnt, m_stall);
    else n_pass++;
    in_instr = 32'h4000_000C;
    in_pc4 = 32'd12;
    tick();
    tick();
    n_total++;
    if (in_ready !== 1'b0 || stall_cnt !== m_stall || out_pc4 !== 32'd4)
      $display("FAIL bp_hold: ready=%b stall=%0d pc4=%0d want 0 %0d 4",
               in_ready, stall_cnt, out_pc4, m_stall);
    else n_pass++;
    out_ready = 1'b1;
    guard = 0;
    while (exp_out_q.size() < 3 && guard < 20) begin
      if (exp_q.size() + exp_out_q.size() >= 3 && in_valid && exp_q.size() < 2)
        in_valid = 1'b1;
      tick();
      if (exp_out_q.size() + exp_q.size() >= 3) in_valid = 1'b0;
      guard++;
    end
    tick();
    n_total++;
    if (got_q.size() !== 3 || exp_out_q.size() !== 3 || out_valid !== 1'b0)
      $display("FAIL bp_count: got=%0d model=%0d valid=%b want 3 3 0",
               got_q.size(), exp_out_q.size(), out_valid);
    else n_pass++;
    while (got_q.size() != 0 && exp_out_q.size() != 0) begin
      logic [63:0] g, e;
      g = got_q.pop_front();
      e = exp_out_q.pop_front();
      n_total++;
      if (g !== e) $display("FAIL bp_order: got %h want %h", g, e);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1;
    in_instr = 32'h5000_0001;
    in_pc4 = 32'd4;
    tick();
    in_instr = 32'h6000_0002;
    in_pc4 = 32'd8;
    tick();
    in_instr = 32'h7000_0003;
    in_pc4 = 32'd12;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 || out_pc4 !== 32'h0)
      $display("FAIL flush_full: v=%b rdy=%b instr=%h pc4=%0d want 0 1 0 0",
               out_valid, in_ready, out_instr, out_pc4);
    else n_pass++;
    in_valid = 1'b1;
    in_instr = 32'h8000_0004;
    in_pc4 = 32'd16;
    tick();
    in_instr = 32'h8800_0005;
    in_pc4 = 32'd20;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    in_instr = 32'hC000_0006;
    in_pc4 = 32'd24;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_total++;
    if (got_q.size() !== 1 || exp_out_q.size() !== 1)
      $display("FAIL flush_count: got=%0d model=%0d want 1", got_q.size(), exp_out_q.size());
    else n_pass++;
    while (got_q.size() != 0 && exp_out_q.size() != 0) begin
      logic [63:0] g, e;
      g = got_q.pop_front();
      e = exp_out_q.pop_front();
      n_total++;
      if (g !== e) $display("FAIL flush_order: got %h want %h", g, e);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1'b1;
    in_instr = 32'hD000_0001;
    in_pc4 = 32'd4;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_total++;
    if (stall_cnt !== m_stall || stall_cnt !== 4'd10)
      $display("FAIL sat_mid: got %0d want 10", stall_cnt);
    else n_pass++;
    for (int i = 0; i < 10; i++) tick();
    n_total++;
    if (stall_cnt !== 4'd15 || m_stall !== 4'd15)
      $display("FAIL sat_top: got %0d want 15", stall_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int gaps;
    do_reset();
    out_ready = 1'b1;
    gaps = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_instr = $urandom();
      in_pc4 = 32'(4 * (i + 1));
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b1) gaps++;
    end
    in_valid = 1'b0;
    tick();
    n_total++;
    if (gaps !== 0) $display("FAIL b2b_throughput: gaps=%0d want 0", gaps);
    else n_pass++;
    n_total++;
    if (got_q.size() !== 8 || exp_out_q.size() !== 8 || stall_cnt !== 4'd0)
      $display("FAIL b2b_count: got=%0d model=%0d stall=%0d want 8 8 0",
               got_q.size(), exp_out_q.size(), stall_cnt);
    else n_pass++;
    while (got_q.size() != 0 && exp_out_q.size() != 0) begin
      logic [63:0] g, e;
      g = got_q.pop_front();
      e = exp_out_q.pop_front();
      n_total++;
      if (g !== e) $display("FAIL b2b_order: got %h want %h", g, e);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = 32'h0;
    in_pc4 = 32'h0;
    flush = 1'b0;
    out_ready = 1'b0;
    m_stall = 4'h0;
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_saturation();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Parametrised IF/ID pipeline stage for the image-filter processor. It replaces the free-running IF/ID latch with a valid/ready handshake stage and adds a 2-entry skid buffer, flush-to-bubble, and instruction field decode. It sits between the fetch unit (PC+4, instruction memory) and the decode/register-file stage. It also exports a saturating stall-cycle counter for performance debug.

Parameters:
PC_W, 32, width of the PC+4 path
NOP_INSTR, 32'h0000_0000, instruction word presented on all field outputs when the stage is empty (bubble)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  fetch offers instruction
in_ready  out  1  stage can accept; registered, equals !skid_valid
in_instr  in  32  fetched instruction word
in_pc4  in  PC_W  PC+4 of fetched instruction
flush  in  1  discard all held and incoming entries (branch taken)
out_valid  out  1  main entry valid toward decode
out_ready  in  1  decode accepts this cycle
out_instr  out  32  held instruction (NOP_INSTR when empty)
out_pc4  out  PC_W  held PC+4 (0 when empty)
opcode  out  4  out_instr[31:28]
cond  out  2  out_instr[27:26]
f  out  2  out_instr[25:24]
rg  out  4  out_instr[23:20]
rp  out  4  out_instr[19:16]
rs  out  4  out_instr[15:12]
inm  out  16  out_instr[15:0]
label  out  24  out_instr[23:0]
stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating

Behaviour:
- Reset (async, rst=1): main_valid=0, skid_valid=0, main/skid instr=NOP_INSTR, pc4 regs=0, stall_cnt=0; thus out_valid=0, in_ready=1, fields decode NOP_INSTR.
- Accept: acc = in_valid && in_ready. Deliver: dlv = out_valid && out_ready.
- Main register update on clk edge (no flush):
  - main empty or dlv: load from skid if skid_valid (skid_valid<=0, and if acc, in goes into skid), else load in if acc, else main_valid<=0.
  - main full and !out_ready: hold; if acc, capture input in skid (skid_valid<=1).
- Latency 1 cycle in->out when unobstructed; full throughput 1 instr/cycle with out_ready=1 continuously; strict program order.
- in_ready is a flop output (no combinational path from out_ready); skid absorbs the one extra word accepted while ready deasserts.
- Flush: next edge main_valid=0, skid_valid=0; any input accepted that cycle is discarded; data regs load NOP_INSTR and pc4 0. Flush has priority over every other event including simultaneous dlv (that delivery still counts as consumed by decode).
- Field outputs: pure combinational slices of out_instr; with out_valid=0, out_instr=NOP_INSTR so decode sees a bubble.
- stall_cnt: +1 on each cycle out_valid && !out_ready; holds at 2^CNT_W-1; cleared only by rst.
- Reset mid-operation: all entries dropped immediately, no partial output.

Decomposition:
- Package if_id_pkg: field bit-position constants (OPC_HI/LO, COND, F, RG, RP, RS, INM, LABEL), INSTR_W=32, default NOP word.
- One sub-module: if_id_field_decode (combinational slicer, reused by later ID/EX stages).

Test Plan:
- Reset: assert rst mid-stream with both entries full -> out_valid=0, in_ready=1, opcode=0, stall_cnt=0 immediately (no clock).
- Decode: push 32'h0001_7000, pc4=4, out_ready=1 -> next cycle out_valid=1, opcode=0, rg=0, rp=1, rs=7, inm=16'h7000, out_pc4=4; push 32'h1175_B000, pc4=8 -> opcode=1, cond=0, f=1, rg=7, rp=5, rs=4'hB, label=24'h75B000.
- Field extremes: 32'h9E7F_1234 -> opcode=9, cond=3, f=2, rg=7, rp=4'hF, rs=1, inm=16'h1234, label=24'h7F1234.
- Backpressure/skid: stream pc4=4,8,12 with out_ready=0 after first -> in_ready drops after 2 held entries, stall_cnt increments each cycle; release out_ready -> outputs 4,8,12 in order, no loss or duplication.
- Flush: both entries full, in_valid=1, flush=1 for one cycle -> next cycle out_valid=0, in_ready=1, out_instr=NOP_INSTR; flushed words never appear.
- Saturation: CNT_W=4, hold out_ready=0 for 20 cycles with valid data -> stall_cnt stops at 15.
